mem_stage_unit: RTL and testbench
=================================

Name: mem_stage_unit

Overview:
- Consumer side of the EXE/MEM pipeline register.
- Takes the registered mem_* control/data, runs the data-memory access over a req/ack bus, stalls the pipeline until the access completes, and holds the MEM/WB pipeline register that feeds writeback.
- Sits between the EXE/MEM register and the writeback mux.
- Upstream must hold all mem_* inputs stable while mem_stall=1.

Parameters:
TIMEOUT, 15, max REQ cycles waiting for dm_ack before bus error (1..2^CNT_W-1)
CNT_W, 4, width of timeout counter

Ports:
clk  in  1  clock, rising edge
clrn  in  1  asynchronous active-low reset
mem_wreg  in  1  instruction writes register file
mem_m2reg  in  1  load (result from memory)
mem_wmem  in  1  store
mem_alu  in  32  ALU result / effective address
mem_b  in  32  store data
mem_rn  in  5  destination register number
dm_req  out  1  memory request, held until ack
dm_we  out  1  1=write, 0=read
dm_addr  out  32  word-aligned address
dm_wdata  out  32  store data
dm_ack  in  1  memory completion, single-cycle pulse
dm_rdata  in  32  read data, valid with dm_ack
mem_stall  out  1  freeze PC/IF/ID/EXE and EXE/MEM register
mem_align_err  out  1  one-cycle pulse, misaligned access suppressed
mem_bus_err  out  1  one-cycle pulse, ack timeout
wb_wreg, wb_m2reg  out  1 each  MEM/WB control
wb_alu, wb_mo  out  32 each  MEM/WB ALU result and load data
wb_rn  out  5  MEM/WB destination

Behaviour:
- Reset (clrn=0, async): state IDLE, counter 0, all outputs 0. A reset mid-access drops dm_req immediately; no bus error is raised.
- access = (mem_m2reg | mem_wmem) & (mem_alu[1:0]==0).
- misaligned = (mem_m2reg | mem_wmem) & (mem_alu[1:0]!=0).
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - If access: mem_stall=1 (combinational). Next state REQ. Register dm_req=1, dm_we=mem_wmem, dm_addr={mem_alu[31:2],2'b00}, dm_wdata=mem_b. Counter cleared.
  - If misaligned: no request, no stall. mem_align_err pulses the same cycle (combinational, IDLE only). wb_wreg captured as 0.
- REQ:
  - mem_stall=1.
  - dm_ack=1: latch dm_rdata into the read-data holding reg (for reads only), drop dm_req, go to DONE.
  - Else counter+1. On reaching TIMEOUT with no ack: drop dm_req, pulse mem_bus_err next cycle, holding reg=0, flag the access as failed, go to DONE.
  - dm_ack on the same cycle as the timeout: the ack wins.
- DONE: mem_stall=0, unconditional return to IDLE. DONE never launches a new request, even though the same instruction is still present.
- dm_ack outside REQ is ignored.
- Stall length: ack in the k-th REQ cycle gives k+1 stall cycles (minimum 2). A non-memory instruction gives 0.
- MEM/WB register, updated on every clk edge:
  - mem_stall=1: bubble. wb_wreg<=0 and wb_m2reg<=0; other wb_* hold.
  - mem_stall=0: wb_alu<=mem_alu, wb_rn<=mem_rn, wb_m2reg<=mem_m2reg, wb_mo<=holding reg (for a load in DONE), else dm_rdata is don't-care and wb_mo holds 0.
  - wb_wreg<=mem_wreg, except forced 0 for a misaligned load or a failed (timed-out) load.
- Stores never alter the register file through this block; wb_wreg follows mem_wreg, which is 0 for stores.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, REQ=2'd1, DONE=2'd2) and the TIMEOUT default. The EXE/WB pipeline packages reuse these.
- One natural sub-module: mem_wb_register, the pipeline register with bubble-on-stall and async active-low clear.
- The FSM, counter and bus driving stay in the top level.

Test Plan:
- ALU op, mem_alu=0x0000_1234, mem_wreg=1, rn=5 -> no stall, no dm_req; next edge wb_alu=0x1234, wb_wreg=1, wb_rn=5.
- Load, addr 0x100, ack in the 1st REQ cycle with rdata 0xDEAD_BEEF -> stall for 2 cycles, dm_addr=0x100, dm_we=0; after DONE: wb_mo=0xDEADBEEF, wb_m2reg=1, wb_wreg=1; bubbles (wb_wreg=0) during the stall.
- Store, addr 0x204, data 0x55AA_55AA, ack after 3 REQ cycles -> dm_we=1, dm_wdata=0x55AA55AA, stall for 4 cycles, exactly one dm_req burst.
- Load, addr 0x102 -> mem_align_err one-cycle pulse, no dm_req, no stall, wb_wreg=0.
- Load with ack never arriving, TIMEOUT=15 -> dm_req high for 15 cycles, then mem_bus_err pulse, wb_wreg=0, wb_mo=0, pipeline resumes.
- clrn low while in REQ -> dm_req=0 and mem_stall=0 immediately, all wb_* = 0; after release, a new load completes normally.

Source files
------------

// File: rtl/mem_stage_unit_pkg.sv
// Shared definitions for the MEM stage and neighbouring pipeline stages.
// Contents:
//   mem_state_e      - memory-access FSM encoding (IDLE/REQ/DONE)
//   TIMEOUT_DEFAULT  - default number of REQ cycles to wait for dm_ack
//   CNT_W_DEFAULT    - default width of the ack-timeout counter
package mem_stage_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    localparam int TIMEOUT_DEFAULT = 15;
    localparam int CNT_W_DEFAULT   = 4;

endpackage

// File: rtl/mem_stage_unit_mem_wb.sv
// MEM/WB pipeline register with bubble insertion.
// Ports:
//   clk_i, rst_ni   - clock and asynchronous active-low clear
//   stall_i         - 1: insert a bubble (write enables cleared, data held)
//   wreg_i, m2reg_i - control bits to capture when not stalled
//   alu_i, mo_i     - ALU result and load data to capture
//   rn_i            - destination register number
//   *_o             - registered copies feeding writeback
module mem_wb_register (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        wreg_i,
    input  logic        m2reg_i,
    input  logic [31:0] alu_i,
    input  logic [31:0] mo_i,
    input  logic [4:0]  rn_i,
    output logic        wreg_o,
    output logic        m2reg_o,
    output logic [31:0] alu_o,
    output logic [31:0] mo_o,
    output logic [4:0]  rn_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wreg_o  <= 1'b0;
            m2reg_o <= 1'b0;
            alu_o   <= '0;
            mo_o    <= '0;
            rn_o    <= '0;
        end else if (stall_i) begin
            // Bubble: nothing may reach the register file; data fields hold.
            wreg_o  <= 1'b0;
            m2reg_o <= 1'b0;
        end else begin
            wreg_o  <= wreg_i;
            m2reg_o <= m2reg_i;
            alu_o   <= alu_i;
            mo_o    <= mo_i;
            rn_o    <= rn_i;
        end
    end

endmodule

// File: rtl/mem_stage_unit.sv
// MEM pipeline stage: performs the data-memory access for loads/stores
// over a req/ack bus, stalls the pipeline while the access is in flight,
// and feeds the MEM/WB register.
// Ports:
//   clk, clrn                     - clock, asynchronous active-low reset
//   mem_wreg/m2reg/wmem/alu/b/rn  - EXE/MEM register contents (held while stalled)
//   dm_req/we/addr/wdata          - registered memory request, held until ack
//   dm_ack, dm_rdata              - single-cycle completion and read data
//   mem_stall                     - freezes the front of the pipeline
//   mem_align_err                 - pulse: misaligned access suppressed
//   mem_bus_err                   - pulse: no ack within TIMEOUT REQ cycles
//   wb_*                          - MEM/WB register outputs
//   dbg_state_o                   - current FSM state
//
// Handshake: dm_req rises when a request is launched and stays high, with
// dm_we/dm_addr/dm_wdata stable, until the cycle in which dm_ack is sampled
// high (or the timeout fires). dm_ack is honoured only in REQ; dm_rdata is
// sampled only together with dm_ack.
module mem_stage_unit
    import mem_stage_unit_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        mem_wreg,
    input  logic        mem_m2reg,
    input  logic        mem_wmem,
    input  logic [31:0] mem_alu,
    input  logic [31:0] mem_b,
    input  logic [4:0]  mem_rn,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        mem_stall,
    output logic        mem_align_err,
    output logic        mem_bus_err,
    output logic        wb_wreg,
    output logic        wb_m2reg,
    output logic [31:0] wb_alu,
    output logic [31:0] wb_mo,
    output logic [4:0]  wb_rn,
    output mem_state_e  dbg_state_o
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_inc;
    logic             dm_req_q, dm_we_q, bus_err_q, failed_q;
    logic [31:0]      dm_addr_q, dm_wdata_q, hold_q;
    logic             is_mem, access, misaligned, timeout_hit;
    logic             wb_wreg_d;
    logic [31:0]      wb_mo_d;

    assign is_mem     = mem_m2reg | mem_wmem;
    assign access     = is_mem & (mem_alu[1:0] == 2'b00);
    assign misaligned = is_mem & (mem_alu[1:0] != 2'b00);
    assign cnt_inc    = cnt_q + 1'b1;
    // An ack in the same cycle as the final count wins over the timeout.
    assign timeout_hit = ~dm_ack & (cnt_inc == TIMEOUT_C);

    // State register
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (access) state_d = ST_REQ;
            ST_REQ:  if (dm_ack || timeout_hit) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;  // never relaunch for the same instruction
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic; gated by clrn so a reset releases the pipeline at once.
    always_comb begin
        mem_stall     = 1'b0;
        mem_align_err = 1'b0;
        case (state_q)
            ST_IDLE: begin
                mem_stall     = clrn & access;
                mem_align_err = clrn & misaligned;
            end
            ST_REQ:  mem_stall = clrn;
            default: ;
        endcase
    end

    // Bus driver, timeout counter and read-data holding register
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            dm_req_q   <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= '0;
            dm_wdata_q <= '0;
            cnt_q      <= '0;
            hold_q     <= '0;
            failed_q   <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            bus_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (access) begin
                        dm_req_q   <= 1'b1;
                        dm_we_q    <= mem_wmem;
                        dm_addr_q  <= {mem_alu[31:2], 2'b00};
                        dm_wdata_q <= mem_b;
                        cnt_q      <= '0;
                        hold_q     <= '0;
                        failed_q   <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (dm_ack) begin
                        dm_req_q <= 1'b0;
                        if (!dm_we_q) hold_q <= dm_rdata;
                    end else if (timeout_hit) begin
                        dm_req_q  <= 1'b0;
                        bus_err_q <= 1'b1;
                        hold_q    <= '0;
                        failed_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dm_req      = dm_req_q;
    assign dm_we       = dm_we_q;
    assign dm_addr     = dm_addr_q;
    assign dm_wdata    = dm_wdata_q;
    assign mem_bus_err = bus_err_q;
    assign dbg_state_o = state_q;

    // Register write is suppressed for a misaligned access or a timed-out load.
    assign wb_wreg_d = mem_wreg & ~misaligned
                     & ~((state_q == ST_DONE) & failed_q & mem_m2reg);
    assign wb_mo_d   = ((state_q == ST_DONE) && mem_m2reg) ? hold_q : 32'h0;

    mem_wb_register u_mem_wb (
        .clk_i   (clk),
        .rst_ni  (clrn),
        .stall_i (mem_stall),
        .wreg_i  (wb_wreg_d),
        .m2reg_i (mem_m2reg),
        .alu_i   (mem_alu),
        .mo_i    (wb_mo_d),
        .rn_i    (mem_rn),
        .wreg_o  (wb_wreg),
        .m2reg_o (wb_m2reg),
        .alu_o   (wb_alu),
        .mo_o    (wb_mo),
        .rn_o    (wb_rn)
    );

endmodule

// File: tb/tb_mem_stage_unit.sv
module tb_mem_stage_unit;
    import mem_stage_unit_pkg::*;

    localparam int TMO = 15;

    typedef struct packed {
        logic        wreg;
        logic        m2reg;
        logic [31:0] alu;
        logic [31:0] mo;
        logic [4:0]  rn;
    } wb_t;

    typedef struct {
        logic        wreg, m2reg, wmem;
        logic [31:0] alu, b;
        logic [4:0]  rn;
        int          k;        // REQ cycle carrying the ack, 0 = never
        logic [31:0] rdata;
        int          exp_stall, exp_req;
        int          exp_align, exp_bus;
        wb_t         exp_wb;
    } vec_t;

    // clock / reset
    logic clk = 1'b0;
    logic clrn = 1'b0;
    always #5 clk = ~clk;

    logic        mem_wreg = 0, mem_m2reg = 0, mem_wmem = 0;
    logic [31:0] mem_alu = 0, mem_b = 0;
    logic [4:0]  mem_rn = 0;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic        dm_ack = 0;
    logic [31:0] dm_rdata = 0;
    logic        mem_stall, mem_align_err, mem_bus_err;
    logic        wb_wreg, wb_m2reg;
    logic [31:0] wb_alu, wb_mo;
    logic [4:0]  wb_rn;
    mem_state_e  dbg_state;

    mem_stage_unit #(.TIMEOUT(TMO), .CNT_W(4)) dut (
        .clk(clk), .clrn(clrn),
        .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_wmem(mem_wmem),
        .mem_alu(mem_alu), .mem_b(mem_b), .mem_rn(mem_rn),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_stall(mem_stall), .mem_align_err(mem_align_err), .mem_bus_err(mem_bus_err),
        .wb_wreg(wb_wreg), .wb_m2reg(wb_m2reg), .wb_alu(wb_alu), .wb_mo(wb_mo),
        .wb_rn(wb_rn), .dbg_state_o(dbg_state)
    );

    // scoreboard
    logic [70:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [70:0] act, input logic [70:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wreg, m2reg, wmem, input logic [31:0] alu, b,
                                input logic [4:0] rn, input int k, input logic [31:0] rdata,
                                input int es, er, ea, eb, input logic ewreg,
                                input logic [31:0] emo);
        vec_t v;
        v.wreg = wreg; v.m2reg = m2reg; v.wmem = wmem; v.alu = alu; v.b = b; v.rn = rn;
        v.k = k; v.rdata = rdata; v.exp_stall = es; v.exp_req = er;
        v.exp_align = ea; v.exp_bus = eb;
        v.exp_wb = '{wreg: ewreg, m2reg: m2reg, alu: alu, mo: emo, rn: rn};
        return v;
    endfunction

    // driver: called at a negedge, returns at the negedge after wb capture
    task automatic run_op(input vec_t v, input string tag);
        int   stalls, reqs, bursts, aligns, buses;
        logic prev_req, done, bubble_ok, we_s;
        logic [31:0] addr_s, wd_s;
        wb_t  got;
        mem_wreg = v.wreg; mem_m2reg = v.m2reg; mem_wmem = v.wmem;
        mem_alu = v.alu; mem_b = v.b; mem_rn = v.rn; dm_ack = 0;
        exp_q.push_back(v.exp_wb);
        stalls = 0; reqs = 0; bursts = 0; aligns = 0; buses = 0;
        prev_req = 0; done = 0; bubble_ok = 1; we_s = 0; addr_s = 0; wd_s = 0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            #1;
            if (dm_req) begin
                reqs++;
                if (!prev_req) begin
                    bursts++; we_s = dm_we; addr_s = dm_addr; wd_s = dm_wdata;
                end
            end
            prev_req = dm_req;
            if (mem_align_err) aligns++;
            if (mem_bus_err) buses++;
            dm_ack   = dm_req && (v.k > 0) && (reqs == v.k);
            dm_rdata = dm_ack ? v.rdata : $urandom();
            if (mem_stall) begin
                stalls++;
                if (stalls > 1 && wb_wreg !== 1'b0) bubble_ok = 0;
            end else begin
                done = 1;
            end
            @(negedge clk);
        end
        dm_ack = 0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s done: stall never released within 40 cycles", tag);
        end
        chk({tag, " stall"}, 71'(stalls), 71'(v.exp_stall));
        chk({tag, " req"}, 71'(reqs), 71'(v.exp_req));
        chk({tag, " bursts"}, 71'(bursts), 71'(v.exp_req > 0 ? 1 : 0));
        chk({tag, " align"}, 71'(aligns), 71'(v.exp_align));
        chk({tag, " bus"}, 71'(buses), 71'(v.exp_bus));
        if (v.exp_req > 0) begin
            chk({tag, " we"}, 71'(we_s), 71'(v.wmem));
            chk({tag, " addr"}, 71'(addr_s), 71'(v.alu & 32'hFFFF_FFFC));
            chk({tag, " wdata"}, 71'(wd_s), 71'(v.b));
        end
        if (v.exp_stall > 1) chk({tag, " bubble"}, 71'(bubble_ok), 71'(1));
        got = '{wreg: wb_wreg, m2reg: wb_m2reg, alu: wb_alu, mo: wb_mo, rn: wb_rn};
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s sb: expected queue empty", tag);
        end else begin
            chk({tag, " wb"}, got, exp_q.pop_front());
        end
    endtask

    vec_t vecs[9];

    initial begin
        vec_t rv;
        //            wreg m2r wmem alu           b             rn  k   rdata         st  rq  al bu ewreg emo
        vecs[0] = mk(1, 0, 0, 32'h0000_1234, 32'h0,        5,  0,  32'h0,        0,  0,  0, 0, 1, 32'h0);
        vecs[1] = mk(1, 1, 0, 32'h0000_0100, 32'h0,        7,  1,  32'hDEAD_BEEF, 2,  1,  0, 0, 1, 32'hDEAD_BEEF);
        vecs[2] = mk(0, 0, 1, 32'h0000_0204, 32'h55AA_55AA, 0, 3,  32'h0,        4,  3,  0, 0, 0, 32'h0);
        vecs[3] = mk(1, 1, 0, 32'h0000_0102, 32'h0,        3,  1,  32'h0,        0,  0,  1, 0, 0, 32'h0);
        vecs[4] = mk(1, 1, 0, 32'h0000_0300, 32'h0,        9,  0,  32'h0,        16, 15, 0, 1, 0, 32'h0);
        vecs[5] = mk(1, 1, 0, 32'h0000_0400, 32'h0,        31, 2,  32'h1234_5678, 3,  2,  0, 0, 1, 32'h1234_5678);
        vecs[6] = mk(0, 0, 1, 32'h0000_0207, 32'h1111_2222, 0, 1,  32'h0,        0,  0,  1, 0, 0, 32'h0);
        vecs[7] = mk(1, 1, 0, 32'h0000_0500, 32'h0,        12, 15, 32'hCAFE_F00D, 16, 15, 0, 0, 1, 32'hCAFE_F00D);
        vecs[8] = mk(1, 0, 0, 32'hFFFF_FFFF, 32'h0,        1,  0,  32'h0,        0,  0,  0, 0, 1, 32'h0);

        // reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst outputs", 71'({dm_req, dm_we, dm_addr, mem_stall, mem_bus_err}), 71'(0));
        chk("rst wb", 71'({wb_wreg, wb_m2reg, wb_alu, wb_mo, wb_rn}), 71'(0));
        chk("rst state", 71'(dbg_state), 71'(ST_IDLE));
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // random aligned loads/stores with random ack latency
        for (int i = 0; i < 6; i++) begin
            logic ld;
            logic [31:0] a, d;
            int k;
            ld = 1'($urandom_range(0, 1));
            a  = {$urandom_range(0, 32'h3FFF) , 2'b00};
            d  = $urandom();
            k  = $urandom_range(1, 6);
            rv = mk(ld, ld, ~ld, a, d, 5'($urandom_range(1, 31)), k, d,
                    k + 1, k, 0, 0, ld, ld ? d : 32'h0);
            run_op(rv, $sformatf("rnd%0d", i));
        end

        // reset in the middle of an access
        mem_wreg = 1; mem_m2reg = 1; mem_wmem = 0; mem_alu = 32'h0000_0600; mem_rn = 6;
        repeat (3) @(negedge clk);
        #2;
        clrn = 1'b0;
        #1;
        chk("midrst req", 71'(dm_req), 71'(0));
        chk("midrst stall", 71'(mem_stall), 71'(0));
        chk("midrst wb", 71'({wb_wreg, wb_m2reg, wb_alu, wb_mo, wb_rn}), 71'(0));
        chk("midrst state", 71'(dbg_state), 71'(ST_IDLE));
        @(negedge clk);
        #1;
        chk("midrst buserr", 71'(mem_bus_err), 71'(0));
        @(negedge clk);
        clrn = 1'b1;
        run_op(mk(1, 1, 0, 32'h0000_0600, 32'h0, 6, 2, 32'hA5A5_0F0F, 3, 2, 0, 0, 1,
                  32'hA5A5_0F0F), "postrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
